// File: rtl/cla_pkg.sv
// rtl/cla_pkg.sv - shared constants and sizing helpers for the pipelined CLA adder
package cla_pkg;

    localparam logic ADD = 1'b0;
    localparam logic SUB = 1'b1;

    function automatic int seg_w(input int width, input int stages);
        return width / stages;
    endfunction

    // Elaboration-time guard: operands must split into equal segments.
    function automatic bit width_ok(input int width, input int stages);
        return (stages > 0) && (width >= stages) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/cla_seg.sv
// rtl/cla_seg.sv - combinational SEG_W-bit carry-lookahead segment with generate/propagate
module cla_seg #(
    parameter int SEG_W = 8
) (
    input  logic [SEG_W-1:0] a,
    input  logic [SEG_W-1:0] b,
    input  logic             cin,
    output logic [SEG_W-1:0] s,
    output logic             cout,
    output logic             c_msb
);
    logic [SEG_W-1:0] g;
    logic [SEG_W-1:0] p;
    logic [SEG_W:0]   c;
    logic             run_p;

    // Each carry is expanded as a flat sum of g/p products so no carry depends on its neighbour.
    always_comb begin
        g     = a & b;
        p     = a ^ b;
        c     = '0;
        c[0]  = cin;
        run_p = 1'b0;
        for (int i = 0; i < SEG_W; i++) begin
            c[i+1] = g[i];
            run_p  = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                c[i+1] = c[i+1] | (run_p & g[j]);
                run_p  = run_p & p[j];
            end
            c[i+1] = c[i+1] | (run_p & cin);
        end
    end

    assign s     = p ^ c[SEG_W-1:0];
    assign cout  = c[SEG_W];
    assign c_msb = c[SEG_W-1];

endmodule

// File: rtl/cla_pipe_adder.sv
// rtl/cla_pipe_adder.sv - pipelined carry-lookahead add/sub, one segment resolved per stage
// Define CLA_PIPE_SAT_EN to saturate out_sum[WIDTH-1:0] on signed overflow.
module cla_pipe_adder
    import cla_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_sum,
    output logic             out_ovf
);
    localparam int SEG_W = seg_w(WIDTH, STAGES);

    logic           adv;
    logic           out_valid_q;
    logic [WIDTH:0] out_sum_q;
    logic           out_ovf_q;

    if (!width_ok(WIDTH, STAGES)) begin : g_bad_cfg
        $error("cla_pipe_adder: WIDTH must be a non-zero multiple of STAGES");
    end

    assign adv       = !out_valid_q || out_ready;
    assign in_ready  = adv;
    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_ovf   = out_ovf_q;

    // The A word rotates right by one segment per stage: the segment to resolve is always at
    // the bottom and finished sum segments enter at the top, so after the last stage the word
    // holds the sum in natural order. B only keeps its not-yet-consumed upper segments.
    for (genvar k = 0; k < STAGES; k++) begin : g_st
        localparam int RW = WIDTH - k * SEG_W;

        logic [WIDTH-1:0] w_in;
        logic [RW-1:0]    b_in;
        logic             c_in;
        logic             sub_in;
        logic             v_in;
        logic [SEG_W-1:0] b_seg;
        logic [SEG_W-1:0] s_seg;
        logic             cout;
        logic [WIDTH-1:0] w_d;

        if (k == 0) begin : g_src
            assign w_in   = in_a;
            assign b_in   = in_b;
            assign sub_in = in_sub;
            assign c_in   = (in_sub == SUB);
            assign v_in   = in_valid;
        end else begin : g_src
            assign w_in   = g_st[k-1].g_reg.w_q;
            assign b_in   = g_st[k-1].g_reg.b_q;
            assign sub_in = g_st[k-1].g_reg.sub_q;
            assign c_in   = g_st[k-1].g_reg.c_q;
            assign v_in   = g_st[k-1].g_reg.v_q;
        end

        assign b_seg = (sub_in == ADD) ? b_in[SEG_W-1:0] : ~b_in[SEG_W-1:0];

        if (SEG_W == WIDTH) begin : g_rot
            assign w_d = s_seg;
        end else begin : g_rot
            assign w_d = {s_seg, w_in[WIDTH-1:SEG_W]};
        end

        if (k < STAGES - 1) begin : g_reg
            logic [WIDTH-1:0]    w_q;
            logic [RW-SEG_W-1:0] b_q;
            logic                c_q;
            logic                sub_q;
            logic                v_q;
            logic                c_msb_unused;

            cla_seg #(.SEG_W(SEG_W)) u_seg (
                .a     (w_in[SEG_W-1:0]),
                .b     (b_seg),
                .cin   (c_in),
                .s     (s_seg),
                .cout  (cout),
                .c_msb (c_msb_unused)
            );

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    w_q   <= '0;
                    b_q   <= '0;
                    c_q   <= 1'b0;
                    sub_q <= 1'b0;
                    v_q   <= 1'b0;
                end else if (adv) begin
                    w_q   <= w_d;
                    b_q   <= b_in[RW-1:SEG_W];
                    c_q   <= cout;
                    sub_q <= sub_in;
                    v_q   <= v_in;
                end
            end
        end else begin : g_out
            logic             c_msb;
            logic             ovf_d;
            logic [WIDTH-1:0] res_d;

            cla_seg #(.SEG_W(SEG_W)) u_seg (
                .a     (w_in[SEG_W-1:0]),
                .b     (b_seg),
                .cin   (c_in),
                .s     (s_seg),
                .cout  (cout),
                .c_msb (c_msb)
            );

            assign ovf_d = c_msb ^ cout;

`ifdef CLA_PIPE_SAT_EN
            // On overflow both operands share a sign, so the true result's sign equals cout.
            assign res_d = !ovf_d ? w_d
                         : (cout ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}});
`else
            assign res_d = w_d;
`endif

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    out_valid_q <= 1'b0;
                    out_sum_q   <= '0;
                    out_ovf_q   <= 1'b0;
                end else if (adv) begin
                    out_valid_q <= v_in;
                    out_sum_q   <= {cout, res_d};
                    out_ovf_q   <= ovf_d;
                end
            end
        end
    end

endmodule
